// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle (4-bit address, 32-bit data) between the core master and axil_reg_slave.
// The master modport drives VALIDs/payload/response READYs, and the slave modport drives the rest.
interface axil_reg_slave_if;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;

  modport master (
    output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    output S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    output S_AXI_BREADY,
    output S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BVALID, S_AXI_BRESP,
    input  S_AXI_ARREADY,
    input  S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP
  );

  modport slave (
    input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    input  S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    input  S_AXI_BREADY,
    input  S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BVALID, S_AXI_BRESP,
    output S_AXI_ARREADY,
    output S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP
  );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave with three R/W control regs and one R/O status word. Commit and read-response latency is 1 edge, and B/R are held until READY.
// AW/W stall while BVALID is set, and AR stalls while RVALID is set. AXIL_RO_SLVERR_EN selects SLVERR for writes to reg3.
module axil_reg_slave #(
  parameter logic [31:0] RESET_VAL0 = 32'h0000_0000,
  parameter logic [31:0] RESET_VAL1 = 32'h0000_0000,
  parameter logic [31:0] RESET_VAL2 = 32'h0000_0000
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  axil_reg_slave_if.slave    s_axi,
  output logic [31:0]        o_reg0,
  output logic [31:0]        o_reg1,
  output logic [31:0]        o_reg2,
  input  logic [31:0]        i_status
);

`ifdef AXIL_RO_SLVERR_EN
  localparam logic [1:0] RO_WR_RESP = 2'b10;
`else
  localparam logic [1:0] RO_WR_RESP = 2'b00;
`endif
  localparam logic [1:0] RESP_OKAY = 2'b00;

  logic        aw_held_q, aw_held_d;
  logic [1:0]  aw_sel_q, aw_sel_d;
  logic        w_held_q, w_held_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] reg0_q, reg0_d;
  logic [31:0] reg1_q, reg1_d;
  logic [31:0] reg2_q, reg2_d;

  logic        awready, wready, arready;
  logic        aw_hs, w_hs, ar_hs, commit;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                       s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

  assign awready = !aw_held_q && !bvalid_q;
  assign wready  = !w_held_q && !bvalid_q;
  assign arready = !rvalid_q;

  assign aw_hs = s_axi.S_AXI_AWVALID && awready;
  assign w_hs  = s_axi.S_AXI_WVALID && wready;
  assign ar_hs = s_axi.S_AXI_ARVALID && arready;

  // A side that is already held takes precedence over the live bus for the commit payload.
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_sel  = aw_held_q ? aw_sel_q : s_axi.S_AXI_AWADDR[3:2];
  assign wr_data = w_held_q ? w_data_q : s_axi.S_AXI_WDATA;
  assign wr_strb = w_held_q ? w_strb_q : s_axi.S_AXI_WSTRB;

  always_comb begin
    aw_held_d = aw_held_q;
    aw_sel_d  = aw_sel_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    reg0_d    = reg0_q;
    reg1_d    = reg1_q;
    reg2_d    = reg2_q;

    if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_d = 1'b0;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      case (wr_sel)
        2'd0:    reg0_d  = apply_strb(reg0_q, wr_data, wr_strb);
        2'd1:    reg1_d  = apply_strb(reg1_q, wr_data, wr_strb);
        2'd2:    reg2_d  = apply_strb(reg2_q, wr_data, wr_strb);
        default: bresp_d = RO_WR_RESP;
      endcase
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_sel_d  = s_axi.S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = s_axi.S_AXI_WDATA;
        w_strb_d = s_axi.S_AXI_WSTRB;
      end
    end
  end

  // Read captures the pre-write register value, so a same-edge write is not visible yet.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      case (s_axi.S_AXI_ARADDR[3:2])
        2'd0:    rdata_d = reg0_q;
        2'd1:    rdata_d = reg1_q;
        2'd2:    rdata_d = reg2_q;
        default: rdata_d = i_status;
      endcase
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      aw_held_q <= 1'b0;
      aw_sel_q  <= 2'd0;
      w_held_q  <= 1'b0;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      reg0_q    <= RESET_VAL0;
      reg1_q    <= RESET_VAL1;
      reg2_q    <= RESET_VAL2;
    end else begin
      aw_held_q <= aw_held_d;
      aw_sel_q  <= aw_sel_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      reg0_q    <= reg0_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = RESP_OKAY;

  assign o_reg0 = reg0_q;
  assign o_reg1 = reg1_q;
  assign o_reg2 = reg2_q;

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite slave that terminates the core's AXI master port: same 4-bit address, 32-bit data, WSTRB, BRESP/RRESP.
- Holds four 32-bit word registers. Regs 0–2 are read/write control registers driven out to FPGA IO logic. Reg 3 is a read-only status word sampled from fabric.
- One outstanding write and one outstanding read; the AW and W channels are accepted independently.

Parameters:
- RESET_VAL0, 32'h0000_0000, reset value of reg0
- RESET_VAL1, 32'h0000_0000, reset value of reg1
- RESET_VAL2, 32'h0000_0000, reset value of reg2

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_AWADDR  in  4  byte address; [3:2] selects register, [1:0] ignored
- S_AXI_AWPROT  in  3  ignored
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables; bit k enables WDATA[8k+7:8k]
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_BRESP  out  2  write response code
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_ARADDR  in  4  byte address; [3:2] selects register
- S_AXI_ARPROT  in  3  ignored
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response, always 2'b00
- o_reg0, o_reg1, o_reg2  out  32 each  current register contents
- i_status  in  32  value returned for reg3 reads, sampled at AR handshake

Behaviour:
- Reset (async assert, sync release):
  - aw_held, w_held, BVALID, RVALID all 0.
  - BRESP=0, RDATA=0, RRESP=0.
  - o_regN = RESET_VALN.
  - Any in-flight transaction is dropped; no response is issued for it after reset.
- Write-channel readiness: S_AXI_AWREADY = !aw_held && !BVALID; S_AXI_WREADY = !w_held && !BVALID.
- Handshakes:
  - An AW handshake without W available latches the address into an AW holding register; aw_held=1.
  - A W handshake without AW available latches WDATA/WSTRB; w_held=1.
- Write commit happens at the rising edge where both address and data are available, each either held or handshaking in that cycle:
  - The target register updates its bytes under WSTRB (WSTRB=0 leaves it unchanged).
  - BVALID rises; aw_held and w_held clear.
  - Latency: same-cycle AW+W handshake at edge N gives the register update and BVALID=1 from edge N.
- Write response:
  - BVALID stays high until the BREADY handshake; BRESP is stable while BVALID=1.
  - No new AW or W is accepted while BVALID=1.
  - The BVALID&BREADY cycle re-opens AWREADY/WREADY on the next cycle (no same-cycle bypass).
- Write to reg3: data discarded, no register changes; BRESP per the optional feature.
- Read path:
  - S_AXI_ARREADY = !RVALID.
  - At the AR handshake edge: RDATA captures regN (N=ARADDR[3:2]) or i_status for N=3; RVALID=1; RRESP=2'b00.
  - RDATA is held stable until the RVALID&RREADY edge, then RVALID=0.
  - Read latency is 1 cycle (AR handshake edge → RVALID).
- Read/write in the same cycle to the same register: the read returns the pre-write value.
- Read and write paths are fully independent and may complete in any order.

Optional Feature:
- Macro: AXIL_RO_SLVERR_EN.
- Defined: a write to reg3 returns BRESP=2'b10 (SLVERR). The read path is unchanged.
- Undefined: a write to reg3 returns BRESP=2'b00 (OKAY) and is silently dropped.

Test Plan:
- AW and W asserted together, addr 4'h4, WDATA 32'hDEADBEEF, WSTRB 4'hF:
  - o_reg1=DEADBEEF and BVALID=1 one edge later, BRESP=0.
  - AWREADY=WREADY=0 until BREADY.
- AW addr 4'h0 at cycle 0, W 32'h12345678 WSTRB 4'hF at cycle 3:
  - AWREADY low from cycle 1; o_reg0 updates and BVALID=1 only after the cycle-3 W handshake.
- reg2=32'hAABBCCDD, then write 32'h11223344 with WSTRB 4'b0101 → o_reg2=32'hAA22CC44.
- i_status=32'hCAFE0001, AR addr 4'hC, RREADY held low 5 cycles:
  - RVALID=1 and RDATA=CAFE0001 constant throughout, ARREADY=0 throughout.
  - RVALID drops the edge after RREADY=1.
- Write 32'hFFFFFFFF to addr 4'hC:
  - o_reg0..2 unchanged.
  - BRESP=2'b10 with AXIL_RO_SLVERR_EN defined, 2'b00 without.
- W handshake accepted (w_held=1), then i_reset_n pulsed low mid-cycle:
  - All VALIDs drop immediately and o_regN return to RESET_VALN.
  - After release, a fresh AW alone does not trigger a commit.
